wb_commit_stage: RTL and testbench

Parametrised writeback/commit stage. Sits after the MEM stage and before the register file, the CSR unit and the trace/debug port. It registers one instruction from MEM and resolves its exceptions with a parametrised priority table. It drives the GPR write, the CSR exception/ertn signalling and a forwarding bus. Retired instructions are buffered in a TRACE_DEPTH-entry commit-trace FIFO with valid/ready backpressure that stalls the stage when full.

---
 rtl/wb_commit_stage.sv | 190 +++++++++++++++++++
 tb/tb_wb_commit_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: registers one instruction from MEM, resolves its
// exceptions by a fixed priority table, drives the GPR write, the CSR
// exception/ertn signals and the forwarding bus, and buffers retired
// instructions in a small commit-trace FIFO that stalls the stage when full.
module wb_commit_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int EXC_N = 6,
  parameter int ECODE_W = 6,
  parameter logic [EXC_N*ECODE_W-1:0] EXC_ECODES = {6'h9, 6'hd, 6'h8, 6'hc, 6'hb, 6'h0},
  parameter int TRACE_DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ms_to_ws_valid,
  output logic              ws_allowin,
  input  logic [DATA_W-1:0] ms_to_ws_pc,
  input  logic              ms_to_ws_gr_we,
  input  logic [REG_AW-1:0] ms_to_ws_dest,
  input  logic [DATA_W-1:0] ms_to_ws_result,
  input  logic              ms_to_ws_csr_sel,
  input  logic [EXC_N-1:0]  ms_to_ws_exc,
  input  logic              ms_to_ws_ertn,
  input  logic [DATA_W-1:0] ms_to_ws_badv,
  input  logic [DATA_W-1:0] csr_rvalue,
  output logic              wb_ex,
  output logic [ECODE_W-1:0] wb_ecode,
  output logic [DATA_W-1:0] wb_pc,
  output logic [DATA_W-1:0] wb_vaddr,
  output logic              wb_ertn,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              ws_fwd_valid,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [DATA_W-1:0] trace_pc,
  output logic              trace_we,
  output logic [REG_AW-1:0] trace_wnum,
  output logic [DATA_W-1:0] trace_wdata,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  exc_cnt
);

  localparam int PTR_W = $clog2(TRACE_DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;

  // Lowest set request bit wins; no request yields ecode 0.
  function automatic logic [ECODE_W-1:0] pick_ecode(input logic [EXC_N-1:0] exc);
    logic [ECODE_W-1:0] code;
    code = '0;
    for (int i = EXC_N - 1; i >= 0; i--) begin
      if (exc[i]) begin
        code = EXC_ECODES[i*ECODE_W +: ECODE_W];
      end else begin
        code = code;
      end
    end
    return code;
  endfunction

  logic              ws_valid;
  logic [DATA_W-1:0] pc_r;
  logic              gr_we_r;
  logic [REG_AW-1:0] dest_r;
  logic [DATA_W-1:0] result_r;
  logic              csr_sel_r;
  logic [EXC_N-1:0]  exc_r;
  logic              ertn_r;
  logic [DATA_W-1:0] badv_r;

  logic [DATA_W-1:0] fifo_pc    [TRACE_DEPTH];
  logic              fifo_we    [TRACE_DEPTH];
  logic [REG_AW-1:0] fifo_wnum  [TRACE_DEPTH];
  logic [DATA_W-1:0] fifo_wdata [TRACE_DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;

  logic full;
  logic empty;
  logic pop;
  logic fifo_push_ok;
  logic ws_ready_go;
  logic commit;
  logic any_exc;

  assign empty        = (wptr == rptr);
  assign full         = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                        (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]);
  assign trace_valid  = !empty;
  assign pop          = trace_valid && trace_ready;
  assign fifo_push_ok = !full || pop;
  assign ws_ready_go  = !ws_valid || fifo_push_ok;
  assign ws_allowin   = !ws_valid || ws_ready_go;
  assign commit       = ws_valid && ws_ready_go;
  assign any_exc      = |exc_r;

  assign wb_ex        = commit && any_exc;
  assign wb_ertn      = commit && ertn_r && !any_exc;
  assign wb_ecode     = pick_ecode(exc_r);
  assign wb_pc        = pc_r;
  assign wb_vaddr     = badv_r;
  assign rf_we        = commit && gr_we_r && !any_exc;
  assign rf_waddr     = dest_r;
  assign rf_wdata     = csr_sel_r ? csr_rvalue : result_r;
  assign ws_fwd_valid = ws_valid;

  // Head of the trace FIFO is read straight from storage (no bypass).
  assign trace_pc    = fifo_pc[rptr[IDX_W-1:0]];
  assign trace_we    = fifo_we[rptr[IDX_W-1:0]];
  assign trace_wnum  = fifo_wnum[rptr[IDX_W-1:0]];
  assign trace_wdata = fifo_wdata[rptr[IDX_W-1:0]];

  // Stage valid bit and instruction fields; exceptions and ertn flush the stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_valid  <= 1'b0;
      pc_r      <= '0;
      gr_we_r   <= 1'b0;
      dest_r    <= '0;
      result_r  <= '0;
      csr_sel_r <= 1'b0;
      exc_r     <= '0;
      ertn_r    <= 1'b0;
      badv_r    <= '0;
    end else begin
      if (commit && (wb_ex || wb_ertn)) begin
        ws_valid <= 1'b0;
      end else if (ws_allowin) begin
        ws_valid <= ms_to_ws_valid;
      end else begin
        ws_valid <= ws_valid;
      end
      if (ms_to_ws_valid && ws_allowin) begin
        pc_r      <= ms_to_ws_pc;
        gr_we_r   <= ms_to_ws_gr_we;
        dest_r    <= ms_to_ws_dest;
        result_r  <= ms_to_ws_result;
        csr_sel_r <= ms_to_ws_csr_sel;
        exc_r     <= ms_to_ws_exc;
        ertn_r    <= ms_to_ws_ertn;
        badv_r    <= ms_to_ws_badv;
      end else begin
        pc_r <= pc_r;
      end
    end
  end

  // Trace FIFO storage and pointers; every commit pushes one entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_we[i]    <= 1'b0;
        fifo_wnum[i]  <= '0;
        fifo_wdata[i] <= '0;
      end
    end else begin
      if (commit) begin
        fifo_pc[wptr[IDX_W-1:0]]    <= pc_r;
        fifo_we[wptr[IDX_W-1:0]]    <= rf_we;
        fifo_wnum[wptr[IDX_W-1:0]]  <= rf_waddr;
        fifo_wdata[wptr[IDX_W-1:0]] <= rf_wdata;
        wptr <= wptr + PTR_W'(1);
      end else begin
        wptr <= wptr;
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end else begin
        rptr <= rptr;
      end
    end
  end

  // Free-running retire and exception counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_cnt <= '0;
      exc_cnt    <= '0;
    end else begin
      retire_cnt <= retire_cnt + CNT_W'(commit);
      exc_cnt    <= exc_cnt + CNT_W'(wb_ex);
    end
  end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage: commit timing, exception priority,
// CSR data selection, ertn, trace FIFO backpressure/wrap and async reset.
module tb_wb_commit_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_to_ws_pc;
  logic        ms_to_ws_gr_we;
  logic [4:0]  ms_to_ws_dest;
  logic [31:0] ms_to_ws_result;
  logic        ms_to_ws_csr_sel;
  logic [5:0]  ms_to_ws_exc;
  logic        ms_to_ws_ertn;
  logic [31:0] ms_to_ws_badv;
  logic [31:0] csr_rvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        wb_ertn;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ws_fwd_valid;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic        trace_we;
  logic [4:0]  trace_wnum;
  logic [31:0] trace_wdata;
  logic [31:0] retire_cnt;
  logic [31:0] exc_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  wb_commit_stage dut (
    .clk(clk), .reset(reset),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_to_ws_pc(ms_to_ws_pc), .ms_to_ws_gr_we(ms_to_ws_gr_we),
    .ms_to_ws_dest(ms_to_ws_dest), .ms_to_ws_result(ms_to_ws_result),
    .ms_to_ws_csr_sel(ms_to_ws_csr_sel), .ms_to_ws_exc(ms_to_ws_exc),
    .ms_to_ws_ertn(ms_to_ws_ertn), .ms_to_ws_badv(ms_to_ws_badv),
    .csr_rvalue(csr_rvalue),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
    .wb_ertn(wb_ertn),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ws_fwd_valid(ws_fwd_valid),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_we(trace_we), .trace_wnum(trace_wnum),
    .trace_wdata(trace_wdata),
    .retire_cnt(retire_cnt), .exc_cnt(exc_cnt)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [31:0] pc, input logic gr_we, input logic [4:0] dest,
                         input logic [31:0] res, input logic csr_sel, input logic [5:0] exc,
                         input logic ertn, input logic [31:0] badv);
    ms_to_ws_valid   = 1'b1;
    ms_to_ws_pc      = pc;
    ms_to_ws_gr_we   = gr_we;
    ms_to_ws_dest    = dest;
    ms_to_ws_result  = res;
    ms_to_ws_csr_sel = csr_sel;
    ms_to_ws_exc     = exc;
    ms_to_ws_ertn    = ertn;
    ms_to_ws_badv    = badv;
  endtask

  task automatic idle();
    ms_to_ws_valid   = 1'b0;
    ms_to_ws_gr_we   = 1'b0;
    ms_to_ws_csr_sel = 1'b0;
    ms_to_ws_exc     = 6'd0;
    ms_to_ws_ertn    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    trace_ready   = 1'b0;
    csr_rvalue    = 32'd0;
    ms_to_ws_pc   = 32'd0;
    ms_to_ws_dest = 5'd0;
    ms_to_ws_result = 32'd0;
    ms_to_ws_badv = 32'd0;
    idle();
    #2;
    // Reset state
    chk("rst_allowin", ws_allowin, 1'b1);
    chk("rst_trace_valid", trace_valid, 1'b0);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_wb_ex", wb_ex, 1'b0);
    chk("rst_wb_pc", wb_pc, 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);
    chk("rst_fwd", ws_fwd_valid, 1'b0);
    tick();
    reset = 1'b0;

    // Single add
    trace_ready = 1'b1;
    present(32'h1c00_0000, 1'b1, 5'd5, 32'h1234, 1'b0, 6'd0, 1'b0, 32'd0);
    tick();
    idle();
    chk("add_rf_we", rf_we, 1'b1);
    chk("add_waddr", rf_waddr, 5'd5);
    chk("add_wdata", rf_wdata, 32'h1234);
    chk("add_no_bypass", trace_valid, 1'b0);
    chk("add_retire0", retire_cnt, 32'd0);
    tick();
    chk("add_trace_valid", trace_valid, 1'b1);
    chk("add_trace_pc", trace_pc, 32'h1c00_0000);
    chk("add_trace_we", trace_we, 1'b1);
    chk("add_trace_wnum", trace_wnum, 5'd5);
    chk("add_trace_wdata", trace_wdata, 32'h1234);
    chk("add_retire1", retire_cnt, 32'd1);
    chk("add_rf_we_off", rf_we, 1'b0);
    tick();
    chk("add_popped", trace_valid, 1'b0);

    // Exception beats gr_we and ertn; lowest set bit (bit 1 -> 0x0b) wins
    present(32'h100, 1'b1, 5'd3, 32'h77, 1'b0, 6'b000110, 1'b1, 32'hbad0);
    tick();
    present(32'h200, 1'b1, 5'd4, 32'h88, 1'b0, 6'd0, 1'b0, 32'd0);
    chk("exc_wb_ex", wb_ex, 1'b1);
    chk("exc_ecode", wb_ecode, 6'h0b);
    chk("exc_rf_we", rf_we, 1'b0);
    chk("exc_ertn", wb_ertn, 1'b0);
    chk("exc_pc", wb_pc, 32'h100);
    chk("exc_vaddr", wb_vaddr, 32'hbad0);
    tick();
    idle();
    chk("exc_flush", ws_fwd_valid, 1'b0);
    chk("exc_cnt1", exc_cnt, 32'd1);
    chk("exc_retire2", retire_cnt, 32'd2);
    chk("exc_trace_valid", trace_valid, 1'b1);
    chk("exc_trace_pc", trace_pc, 32'h100);
    chk("exc_trace_we", trace_we, 1'b0);
    tick();
    chk("exc_drained", trace_valid, 1'b0);
    chk("exc_no_refire", exc_cnt, 32'd1);

    // CSR read data selected into GPR write and trace
    csr_rvalue = 32'hdead_beef;
    present(32'h300, 1'b1, 5'd7, 32'h55, 1'b1, 6'd0, 1'b0, 32'd0);
    tick();
    idle();
    chk("csr_wdata", rf_wdata, 32'hdead_beef);
    chk("csr_waddr", rf_waddr, 5'd7);
    tick();
    csr_rvalue = 32'd0;
    #1;
    chk("csr_trace_wdata", trace_wdata, 32'hdead_beef);
    tick();

    // ertn alone
    present(32'h400, 1'b0, 5'd0, 32'd0, 1'b0, 6'd0, 1'b1, 32'd0);
    tick();
    idle();
    chk("ertn_on", wb_ertn, 1'b1);
    chk("ertn_no_ex", wb_ex, 1'b0);
    chk("ertn_rf_we", rf_we, 1'b0);
    tick();
    chk("ertn_one_cycle", wb_ertn, 1'b0);
    chk("ertn_trace_pc", trace_pc, 32'h400);
    chk("ertn_trace_we", trace_we, 1'b0);
    chk("ertn_retire4", retire_cnt, 32'd4);
    tick();
    chk("ertn_drained", trace_valid, 1'b0);

    // Backpressure: 6 instructions, pc i*4, result pc*4, trace_ready low
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      present(32'(i * 4), 1'b1, 5'(i + 1), 32'(i * 16), 1'b0, 6'd0, 1'b0, 32'd0);
      tick();
    end
    present(32'd20, 1'b1, 5'd6, 32'h50, 1'b0, 6'd0, 1'b0, 32'd0);
    chk("bp_stall_allowin", ws_allowin, 1'b0);
    chk("bp_stall_rf_we", rf_we, 1'b0);
    chk("bp_stall_pc", wb_pc, 32'd16);
    chk("bp_head_pc", trace_pc, 32'd0);
    chk("bp_retire8", retire_cnt, 32'd8);
    tick();
    chk("bp_still_stalled", ws_allowin, 1'b0);
    chk("bp_still_pc", wb_pc, 32'd16);
    chk("bp_still_retire8", retire_cnt, 32'd8);
    trace_ready = 1'b1;
    #1;
    chk("bp_pushpop_rf_we", rf_we, 1'b1);
    chk("bp_pushpop_wdata", rf_wdata, 32'h40);
    chk("bp_pushpop_allowin", ws_allowin, 1'b1);
    tick();
    trace_ready = 1'b0;
    idle();
    #1;
    chk("bp_full_again", ws_allowin, 1'b0);
    chk("bp_head_after", trace_pc, 32'd4);
    chk("bp_retire9", retire_cnt, 32'd9);
    for (int k = 1; k <= 5; k++) begin
      chk("bp_order_valid", trace_valid, 1'b1);
      chk("bp_order_pc", trace_pc, 64'(k * 4));
      chk("bp_order_wdata", trace_wdata, 64'(k * 16));
      trace_ready = 1'b1;
      tick();
    end
    chk("bp_empty", trace_valid, 1'b0);
    chk("bp_retire10", retire_cnt, 32'd10);

    // Async reset with 3 entries buffered and one instruction in flight
    trace_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      present(32'h40 + 32'(i * 4), 1'b1, 5'd9, 32'(i), 1'b0, 6'd0, 1'b0, 32'd0);
      tick();
    end
    idle();
    chk("ar_pre_valid", trace_valid, 1'b1);
    chk("ar_pre_ws", ws_fwd_valid, 1'b1);
    chk("ar_pre_retire", retire_cnt, 32'd13);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_trace_valid", trace_valid, 1'b0);
    chk("ar_retire", retire_cnt, 32'd0);
    chk("ar_exc_cnt", exc_cnt, 32'd0);
    chk("ar_ws_valid", ws_fwd_valid, 1'b0);
    chk("ar_allowin", ws_allowin, 1'b1);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("ar_no_trace", trace_valid, 1'b0);
    chk("ar_no_retire", retire_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
